// File: rtl/csa_64bit.sv
// 64-bit carry-select adder/subtractor with registered sum, carry out and
// unsigned out-of-range flag. Sixteen 4-bit blocks; every block above block 0
// precomputes both carry-in cases and the lower block's carry picks one.
module csa_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        addsum,
    input  logic        clock,
    output logic        overflow,
    input  logic        start,
    input  logic        reset,
    output logic [63:0] sum,
    output logic        cout
);

    localparam int unsigned NumBlocks = 16;
    localparam int unsigned BlockW    = 4;

    // 4-bit ripple adder; result is {carry_out, sum[3:0]}.
    function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y,
                                           input logic ci);
        logic [4:0] r;
        logic       c;
        r = '0;
        c = ci;
        for (int k = 0; k < 4; k++) begin
            r[k] = x[k] ^ y[k] ^ c;
            c    = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
        end
        r[4] = c;
        return r;
    endfunction

    logic [63:0]        b_eff;
    logic [NumBlocks:0] carry;
    logic [63:0]        sum_c;
    logic               ovf_c;

    logic [63:0] sum_d, sum_q;
    logic        cout_d, cout_q;
    logic        ovf_d, ovf_q;

    // Subtraction is A + ~B + 1: invert B and use addsum as the carry-in.
    assign b_eff    = addsum ? ~b : b;
    assign carry[0] = addsum;

    for (genvar i = 0; i < NumBlocks; i++) begin : g_blk
        logic [3:0] a_s, b_s;
        assign a_s = a[i*BlockW +: BlockW];
        assign b_s = b_eff[i*BlockW +: BlockW];

        if (i == 0) begin : g_first
            logic [4:0] r;
            assign r                     = ripple4(a_s, b_s, carry[0]);
            assign sum_c[BlockW-1:0]     = r[3:0];
            assign carry[1]              = r[4];
        end else begin : g_sel
            logic [4:0] r0, r1;
            assign r0 = ripple4(a_s, b_s, 1'b0);
            assign r1 = ripple4(a_s, b_s, 1'b1);
            assign sum_c[i*BlockW +: BlockW] = carry[i] ? r1[3:0] : r0[3:0];
            assign carry[i+1]                = carry[i] ? r1[4]   : r0[4];
        end
    end

    // Unsigned out-of-range: carry in add mode, missing carry (borrow) in subtract mode.
    assign ovf_c = addsum ? ~carry[NumBlocks] : carry[NumBlocks];

    // Load the combinational result on start, otherwise hold.
    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (start) begin
            sum_d  = sum_c;
            cout_d = carry[NumBlocks];
            ovf_d  = ovf_c;
        end
    end

    // Output registers; reset clears them asynchronously and overrides start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_csa_64bit.sv
// Scoreboard bench for csa_64bit: stimulus pushes expected results, a monitor
// pops and compares after each registering edge or on an explicit probe.
module tb_csa_64bit;

    logic [63:0] a, b, sum;
    logic        addsum, clock, overflow, start, reset, cout;

    csa_64bit dut (
        .a        (a),
        .b        (b),
        .addsum   (addsum),
        .clock    (clock),
        .overflow (overflow),
        .start    (start),
        .reset    (reset),
        .sum      (sum),
        .cout     (cout)
    );

    typedef struct {
        string       name;
        logic [63:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   fire_cnt = 0;
    int   served_cnt = 0;
    int   probe_cnt = 0;
    int   probe_done = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count edges on which the DUT registers a new result.
    always @(posedge clock) begin
        if (start && !reset) fire_cnt <= fire_cnt + 1;
    end

    task automatic compare_one();
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %0t: output with empty scoreboard, sum=%h cout=%b ovf=%b",
                     $time, sum, cout, overflow);
        end else begin
            e = q.pop_front();
            if ({sum, cout, overflow} !== {e.s, e.c, e.o}) begin
                errors++;
                $display("FAIL %s: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         e.name, sum, cout, overflow, e.s, e.c, e.o);
            end
        end
    endtask

    // Monitor: check after each registering edge and on each probe request.
    initial begin
        forever begin
            @(negedge clock or probe_cnt);
            while (served_cnt < fire_cnt) begin
                compare_one();
                served_cnt++;
            end
            while (probe_done < probe_cnt) begin
                compare_one();
                probe_done++;
            end
        end
    end

    task automatic issue(input string nm, input logic [63:0] av, input logic [63:0] bv,
                         input logic op, input logic [63:0] es, input logic ec,
                         input logic eo);
        exp_t e;
        e = '{name: nm, s: es, c: ec, o: eo};
        a      = av;
        b      = bv;
        addsum = op;
        start  = 1'b1;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, %0d results not produced, want 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic probe(input string nm, input logic [63:0] es, input logic ec,
                         input logic eo);
        exp_t e;
        e = '{name: nm, s: es, c: ec, o: eo};
        q.push_back(e);
        probe_cnt++;
        for (int i = 0; i < 20 && probe_done != probe_cnt; i++) #1;
        if (probe_done != probe_cnt) begin
            checks++;
            errors++;
            $display("FAIL %s: probe timeout, done=%0d want %0d", nm, probe_done, probe_cnt);
        end
    endtask

    initial begin
        a = '0; b = '0; addsum = 1'b0; start = 1'b0; reset = 1'b0;
        #1 reset = 1'b1;
        #1 probe("reset_state", 64'h0, 1'b0, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        a = 64'h1234; b = 64'h5678;
        @(posedge clock); #1;
        probe("post_reset_hold", 64'h0, 1'b0, 1'b0);

        issue("add_zero", 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        start = 1'b0;
        wait_idle("add_zero");

        issue("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b1);
        start = 1'b0;
        wait_idle("add_wrap");

        // Asynchronous reset, well away from any clock edge.
        @(posedge clock); #1;
        reset = 1'b1;
        #1 probe("async_reset", 64'h0, 1'b0, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        probe("reset_released_hold", 64'h0, 1'b0, 1'b0);

        issue("sub_max_minus_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
        start = 1'b0;
        wait_idle("sub_max_minus_1");

        issue("add_block_carries", 64'h0000_AAAA_BBBB_FFFF, 64'h0000_1000_1234_1001, 1'b0,
              64'h0000_BAAA_CDF0_1000, 1'b0, 1'b0);
        start = 1'b0;
        wait_idle("add_block_carries");

        a = 64'hDEAD_BEEF_0000_0001; b = 64'h0123_4567_89AB_CDEF; addsum = 1'b1;
        @(posedge clock); #1;
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; addsum = 1'b0;
        @(posedge clock); #1;
        probe("hold_start_low", 64'h0000_BAAA_CDF0_1000, 1'b0, 1'b0);

        issue("sub_after_hold", 64'h1111_2222_3333_4444, 64'h1, 1'b1,
              64'h1111_2222_3333_4443, 1'b1, 1'b0);
        start = 1'b0;
        wait_idle("sub_after_hold");

        // Back-to-back starts re-register fresh inputs each edge.
        issue("b2b_add_small", 64'h5, 64'h7, 1'b0, 64'hC, 1'b0, 1'b0);
        issue("b2b_add_msb", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
              64'h0, 1'b1, 1'b1);
        issue("b2b_sub_equal", 64'h5, 64'h5, 1'b1, 64'h0, 1'b1, 1'b0);
        issue("add_full_ripple", 64'h0FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
              64'h1000_0000_0000_0000, 1'b0, 1'b0);
        start = 1'b0;
        wait_idle("back_to_back");

        issue("sub_borrow", 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        start = 1'b0;
        wait_idle("sub_borrow");

        // Start coinciding with reset must be ignored.
        @(posedge clock); #1;
        reset = 1'b1;
        a = 64'h7; b = 64'h9; addsum = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        probe("start_during_reset", 64'h0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;
        probe("after_start_during_reset", 64'h0, 1'b0, 1'b0);

        wait_idle("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_64bit.md
CSA_64BIT -- requirements
Module: csa_64bit

Interface
REQ-001 The block SHALL have no parameters; the width is fixed at 64 bits.
REQ-002 Port clock, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: reset SHALL be asynchronous and active-high.
REQ-004 Port a, input, 64 bits: operand A, unsigned.
REQ-005 Port b, input, 64 bits: operand B, unsigned.
REQ-006 Port addsum, input, 1 bit: operation select; 0 = add (A+B), 1 = subtract (A-B).
REQ-007 Port start, input, 1 bit: when high at a rising clock edge, operands SHALL be consumed and a result registered.
REQ-008 Port sum, output, 64 bits: registered result.
REQ-009 Port cout, output, 1 bit: registered carry out of bit 63.
REQ-010 Port overflow, output, 1 bit: registered unsigned out-of-range flag.
REQ-011 Positional port order SHALL be a, b, addsum, clock, overflow, start, reset, sum, cout.

Function
REQ-012 The adder SHALL be a carry-select structure:
- 16 blocks of 4 bits each.
- Each block above block 0 SHALL compute two ripple sums, one with carry-in 0 and one with carry-in 1.
- Each block's sum and carry SHALL be selected by the carry out of the block below.
- Block 0 SHALL take the operation carry-in directly.
REQ-013 Add mode (addsum=0): result = A + B, carry-in 0.
REQ-014 Subtract mode (addsum=1): result = A + ~B + 1, i.e. B inverted and carry-in 1.
REQ-015 cout SHALL be the raw carry out of bit 63 in both modes.
REQ-016 overflow SHALL be cout in add mode and ~cout in subtract mode (unsigned borrow).
REQ-017 Datapath from a, b, addsum SHALL be combinational into the output registers.
REQ-018 At a rising edge with start=1 and reset=0, sum, cout and overflow SHALL load the combinational result.
- Latency: 1 edge.
- Outputs valid immediately after that edge.
REQ-019 At a rising edge with start=0, outputs SHALL hold their previous values regardless of changes on a, b or addsum.
REQ-020 start held high for consecutive edges SHALL re-register the current inputs on each edge; no busy state, no handshake.
REQ-021 sum SHALL wrap modulo 2^64; no saturation.

Reset
REQ-022 While reset=1, sum SHALL be 64'h0, cout 0 and overflow 0, asynchronously, independent of clock.
REQ-023 reset SHALL take priority over start; a start coinciding with reset SHALL be ignored.
REQ-024 After reset deasserts, outputs SHALL stay 0 until the next start edge.
REQ-025 Reset asserted between starts SHALL discard the held result.

Verification
REQ-026 Add zero:
- Stimulus: add, 0 + 0, start pulse.
- Response: sum=0, cout=0, overflow=0.
REQ-027 Add wrap:
- Stimulus: add, FFFF_FFFF_FFFF_FFFF + 0000_0000_0000_0001, start pulse.
- Response: sum=0, cout=1, overflow=1.
- Then: assert reset.
- Response: sum=0, cout=0, overflow=0 without a clock edge; values held after release.
REQ-028 Subtract:
- Stimulus: subtract, FFFF_FFFF_FFFF_FFFF - 1, start pulse.
- Response: sum=FFFF_FFFF_FFFF_FFFE, cout=1, overflow=0.
REQ-029 Add with internal carries:
- Stimulus: add, 0000_AAAA_BBBB_FFFF + 0000_1000_1234_1001.
- Response: sum=0000_BAAA_CDF0_1000, cout=0, overflow=0.
- Exercises carry propagation across block boundaries.
REQ-030 Hold after start:
- Stimulus: change a/b with start low after a registered result.
- Response: outputs unchanged.
- Then: start pulse with subtract, 1111_2222_3333_4444 - 1.
- Response: sum=1111_2222_3333_4443, cout=1, overflow=0.
REQ-031 Borrow:
- Stimulus: subtract, 0 - 1.
- Response: sum=FFFF_FFFF_FFFF_FFFF, cout=0, overflow=1.
- Then: start coincident with reset.
- Response: outputs remain 0.
